cim_psum_reader: RTL and testbench
==================================

# cim_psum_reader

Readout stage on the output side of the CiM macro. Captures one wide word of NUM_COL signed partial sums in a single cycle, then streams them out one column per beat over a valid/ready interface, sign-extended to OUT_W. It turns the macro's parallel result word into the serial stream consumed by the accumulator/requantizer.

## Interface
- NUM_COL, 8: partial sums per captured word; power of two, ≥2.
- PSUM_W, 12: width of each signed partial sum.
- OUT_W, 16: output data width; must be ≥ PSUM_W.
- IDX_W, $clog2(NUM_COL): column index width (localparam).
- clk  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous abort; drops any word in flight.
- psum_valid_i  in  1  macro result word valid.
- psum_ready_o  out  1  reader can accept a word this cycle.
- psum_i  in  NUM_COL*PSUM_W  packed partial sums; column c at bits [c*PSUM_W +: PSUM_W].
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts beat.
- out_data_o  out  OUT_W  sign-extended partial sum of current column.
- out_idx_o  out  IDX_W  column index of current beat.
- out_last_o  out  1  current beat is column NUM_COL-1.
- busy_o  out  1  a word is held (state STREAM).

## Operation
- States: IDLE, STREAM.
- Accept = psum_valid_i && psum_ready_o. On accept: psum_i → capture register, column counter ← 0, state ← STREAM.
- psum_ready_o = (state==IDLE) || (out_valid_o && out_ready_i && out_last_o); combinational, so a new word can be accepted on the same cycle the final beat of the previous word is taken (zero-bubble back-to-back).
- STREAM: out_valid_o = 1; out_data_o = sign-extend(column[counter]); out_idx_o = counter; out_last_o = (counter==NUM_COL-1).
- Beat = out_valid_o && out_ready_i. On a non-last beat the counter increments. On the last beat: if accept occurs in the same cycle, reload and stay in STREAM; otherwise go to IDLE.
- out_data_o, out_idx_o and out_last_o hold stable while out_valid_o && !out_ready_i (AXI-style; no retraction).
- clear_i: state ← IDLE, counter ← 0, out_valid_o ← 0 next cycle; it has priority over accept and beat in the same cycle. psum_ready_o is forced 0 while clear_i is high. The capture register is not cleared.
- IDLE: out_valid_o = 0, out_last_o = 0; out_data_o and out_idx_o are don't-care but must be driven from registers (no X).
- psum_i is ignored when not accepted; a capture register change is only allowed on accept.

## Timing
- Reset values: state IDLE, counter 0, capture register 0, out_valid_o 0, out_last_o 0, out_idx_o 0, out_data_o 0, busy_o 0; psum_ready_o = 1 once reset is released (clear_i low).
- Latency: accept at edge N → first beat valid in cycle N+1. A word drains in exactly NUM_COL cycles under continuous out_ready_i.
- Throughput: 1 beat/cycle. Under continuous psum_valid_i and out_ready_i, out_valid_o stays high with no gaps.
- Reset asserted mid-stream: outputs take their reset values immediately (asynchronous); the partially streamed word is lost.
- Counter wraps only through reload; it never exceeds NUM_COL-1.

## Structure
- Shared package cim_pkg: reader state enum (IDLE, STREAM), default PSUM_W/OUT_W constants, and a sign-extension function.
- Capture register: one instance of dff with WIDTH = NUM_COL*PSUM_W, en_i = accept, d_i = psum_i. The FSM, counter and output mux live in cim_psum_reader.

## Test plan
- Single word, NUM_COL=8, psum_i columns {0:+5, 1:-1, 2:2047, 3:-2048, 4..7:0}, out_ready_i=1 → 8 consecutive beats idx 0..7, data 0x0005, 0xFFFF, 0x07FF, 0xF800, 0, …; out_last_o only on idx 7; psum_ready_o low for cycles N+1..N+7.
- Backpressure: drop out_ready_i for 3 cycles at idx 2 → idx 2 and its data held stable, valid high, no beat skipped or duplicated.
- Back-to-back: psum_valid_i held high with two words → accept of word 2 coincides with the idx-7 beat of word 1; idx 0 of word 2 follows the next cycle with no gap.
- clear_i at idx 4 together with psum_valid_i → no accept; out_valid_o low next cycle; psum_ready_o high the cycle after clear_i drops; the next word streams from idx 0.
- Async reset at idx 3 → all outputs at reset values before the next edge; after release, a new word streams normally.
- Random valid/ready with scoreboard over 1000 words → output stream equals captured columns in order; every word has exactly NUM_COL beats.

Source files
------------

// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared types, default widths and sign-extension helper for the CiM readout path
package cim_pkg;

    // Reader FSM: IDLE waits for a macro word, STREAM emits one column per beat.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } reader_state_e;

    localparam int DEF_PSUM_W = 12;
    localparam int DEF_OUT_W  = 16;

    // Widest value the helper handles; callers narrow the result with a size cast.
    localparam int SEXT_W = 64;

    // Sign-extend the low 'width' bits of val to SEXT_W bits.
    // Shift the sign bit to the MSB, then arithmetic-shift back down.
    function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] val,
                                                      input int unsigned        width);
        logic signed [SEXT_W-1:0] tmp;
        tmp = $signed(val << (SEXT_W - width));
        return $unsigned(tmp >>> (SEXT_W - width));
    endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - enabled register with asynchronous active-low reset to zero
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Load d_i only when enabled; otherwise hold.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/cim_psum_reader.sv
// rtl/cim_psum_reader.sv - captures a wide partial-sum word and streams it out one column per beat
module cim_psum_reader
    import cim_pkg::*;
#(
    parameter  int NUM_COL = 8,
    parameter  int PSUM_W  = DEF_PSUM_W,
    parameter  int OUT_W   = DEF_OUT_W,
    localparam int IDX_W   = $clog2(NUM_COL)
) (
    input  logic                      clk,
    input  logic                      rst_n_i,
    input  logic                      clear_i,
    input  logic                      psum_valid_i,
    output logic                      psum_ready_o,
    input  logic [NUM_COL*PSUM_W-1:0] psum_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [OUT_W-1:0]          out_data_o,
    output logic [IDX_W-1:0]          out_idx_o,
    output logic                      out_last_o,
    output logic                      busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COL - 1);

    reader_state_e             state_q;
    logic [IDX_W-1:0]          cnt_q;
    logic [NUM_COL*PSUM_W-1:0] capture_q;
    logic [PSUM_W-1:0]         cols [NUM_COL];

    logic accept;
    logic beat;

    // Valid, index and last come straight from state/counter registers, so they
    // cannot change while a beat is stalled by out_ready_i.
    assign out_valid_o = (state_q == ST_STREAM);
    assign busy_o      = out_valid_o;
    assign out_idx_o   = cnt_q;
    assign out_last_o  = out_valid_o && (cnt_q == LAST_IDX);
    assign beat        = out_valid_o && out_ready_i;

    // Ready also opens on the final beat so consecutive words stream without a bubble.
    assign psum_ready_o = !clear_i && ((state_q == ST_IDLE) || (beat && out_last_o));
    assign accept       = psum_valid_i && psum_ready_o;

    // Capture register: only an accepted word may overwrite it; clear leaves it intact.
    dff #(
        .WIDTH (NUM_COL*PSUM_W)
    ) u_capture (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .en_i    (accept),
        .d_i     (psum_i),
        .q_o     (capture_q)
    );

    // Split the captured word into per-column slices for the output mux.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_cols
        assign cols[c] = capture_q[c*PSUM_W +: PSUM_W];
    end

    // Column mux with sign extension; in IDLE this still reflects registered state, never X.
    assign out_data_o = OUT_W'(sign_extend({{(SEXT_W-PSUM_W){1'b0}}, cols[cnt_q]}, PSUM_W));

    // Reader FSM and column counter; clear wins over accept and beat.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                state_q <= ST_STREAM;
                cnt_q   <= '0;
            end
        end else if (beat) begin
            if (out_last_o) begin
                // A word accepted on the last beat reloads; otherwise drop back to idle.
                cnt_q <= '0;
                if (!accept) begin
                    state_q <= ST_IDLE;
                end
            end else begin
                cnt_q <= cnt_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cim_psum_reader.sv
// tb/tb_cim_psum_reader.sv - directed and randomized self-checking bench for cim_psum_reader
module tb_cim_psum_reader;

    localparam int NUM_COL = 8;
    localparam int PSUM_W  = 12;
    localparam int OUT_W   = 16;
    localparam int IDX_W   = 3;
    localparam int WORD_W  = NUM_COL * PSUM_W;

    typedef struct {
        logic [OUT_W-1:0] d;
        int               idx;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              psum_valid;
    logic              psum_ready;
    logic [WORD_W-1:0] psum;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    cim_psum_reader #(
        .NUM_COL (NUM_COL),
        .PSUM_W  (PSUM_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk          (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .psum_valid_i (psum_valid),
        .psum_ready_o (psum_ready),
        .psum_i       (psum),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_idx_o    (out_idx),
        .out_last_o   (out_last),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_col(input logic [WORD_W-1:0] w, input int c);
        logic [PSUM_W-1:0] v;
        v = w[c*PSUM_W +: PSUM_W];
        return {{(OUT_W-PSUM_W){v[PSUM_W-1]}}, v};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [WORD_W-1:0] w, input int c);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_idx"},   32'(out_idx),   32'(c));
        check_eq({tag, "_data"},  32'(out_data),  32'(ref_col(w, c)));
        check_eq({tag, "_last"},  32'(out_last),  32'(c == NUM_COL-1));
    endtask

    task automatic accept_word(input string tag, input logic [WORD_W-1:0] w);
        psum_valid = 1'b1;
        psum       = w;
        #3;
        check_eq({tag, "_acc_rdy"}, 32'(psum_ready), 32'd1);
        next_cycle();
        psum_valid = 1'b0;
        psum       = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic drain(input string tag, input logic [WORD_W-1:0] w, input int stall_at,
                         input int stall_len);
        for (int c = 0; c < NUM_COL; c++) begin
            if (c == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #3;
                    check_beat({tag, "_stall"}, w, c);
                    next_cycle();
                end
                out_ready = 1'b1;
            end
            #3;
            check_beat(tag, w, c);
            next_cycle();
        end
    endtask

    task automatic idle_check(input string tag);
        #3;
        check_eq({tag, "_idle_valid"}, 32'(out_valid),  32'd0);
        check_eq({tag, "_idle_busy"},  32'(busy),       32'd0);
        check_eq({tag, "_idle_last"},  32'(out_last),   32'd0);
        check_eq({tag, "_idle_rdy"},   32'(psum_ready), 32'd1);
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
        logic [WORD_W-1:0] w4;
        logic [OUT_W-1:0]  exp1 [NUM_COL];
        beat_t             q [$];
        beat_t             b;
        bit                acc;
        bit                bt;
        bit                pend;
        int                words_in;
        int                beats;
        int                cycles;

        rst_n      = 1'b0;
        clear      = 1'b0;
        psum_valid = 1'b0;
        psum       = '0;
        out_ready  = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_idx",   32'(out_idx),   32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        check_eq("rst_last",  32'(out_last),  32'd0);
        check_eq("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        #3;
        check_eq("rst_rdy", 32'(psum_ready), 32'd1);
        next_cycle();

        // Single word with hand-computed expectations
        w1 = {12'h000, 12'h000, 12'h000, 12'h000, 12'h800, 12'h7FF, 12'hFFF, 12'h005};
        exp1 = '{16'h0005, 16'hFFFF, 16'h07FF, 16'hF800, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        accept_word("single", w1);
        for (int c = 0; c < NUM_COL; c++) begin
            #3;
            check_eq("single_valid", 32'(out_valid),  32'd1);
            check_eq("single_idx",   32'(out_idx),    32'(c));
            check_eq("single_data",  32'(out_data),   32'(exp1[c]));
            check_eq("single_last",  32'(out_last),   32'(c == NUM_COL-1));
            check_eq("single_rdy",   32'(psum_ready), 32'(c == NUM_COL-1));
            next_cycle();
        end
        idle_check("single");

        // Backpressure at idx 2 for 3 cycles; columns {1,2,3,4,5,6,7,-7}
        w2 = {12'hFF9, 12'h007, 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001};
        accept_word("bp", w2);
        drain("bp", w2, 2, 3);
        idle_check("bp");

        // Back-to-back: word 2 accepted on the last beat of word 1
        w3 = {12'h123, 12'h9AB, 12'h7FE, 12'h801, 12'h0F0, 12'hF0F, 12'h555, 12'hAAA};
        w4 = {12'h001, 12'hFFE, 12'h400, 12'hC00, 12'h3FF, 12'h800, 12'h010, 12'hFF0};
        psum_valid = 1'b1;
        psum       = w3;
        #3;
        check_eq("b2b_acc_rdy", 32'(psum_ready), 32'd1);
        next_cycle();
        psum = w4;
        for (int c = 0; c < NUM_COL; c++) begin
            #3;
            check_beat("b2b_w1", w3, c);
            check_eq("b2b_rdy", 32'(psum_ready), 32'(c == NUM_COL-1));
            next_cycle();
        end
        psum_valid = 1'b0;
        drain("b2b_w2", w4, -1, 0);
        idle_check("b2b");

        // Clear at idx 4 together with a valid word
        accept_word("clr", w2);
        for (int c = 0; c < 4; c++) begin
            #3;
            check_beat("clr_pre", w2, c);
            next_cycle();
        end
        clear      = 1'b1;
        psum_valid = 1'b1;
        psum       = w3;
        #3;
        check_eq("clr_rdy_low", 32'(psum_ready), 32'd0);
        check_beat("clr_at", w2, 4);
        next_cycle();
        clear      = 1'b0;
        psum_valid = 1'b0;
        #3;
        check_eq("clr_valid", 32'(out_valid),  32'd0);
        check_eq("clr_busy",  32'(busy),       32'd0);
        check_eq("clr_idx",   32'(out_idx),    32'd0);
        check_eq("clr_rdy",   32'(psum_ready), 32'd1);
        next_cycle();
        accept_word("clr_next", w4);
        drain("clr_next", w4, -1, 0);
        idle_check("clr");

        // Asynchronous reset at idx 3
        accept_word("arst", w3);
        for (int c = 0; c < 3; c++) begin
            #3;
            check_beat("arst_pre", w3, c);
            next_cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_idx",   32'(out_idx),   32'd0);
        check_eq("arst_data",  32'(out_data),  32'd0);
        check_eq("arst_last",  32'(out_last),  32'd0);
        check_eq("arst_busy",  32'(busy),      32'd0);
        next_cycle();
        rst_n = 1'b1;
        #3;
        check_eq("arst_rdy", 32'(psum_ready), 32'd1);
        next_cycle();
        accept_word("arst_next", w1);
        drain("arst_next", w1, 5, 2);
        idle_check("arst");

        // Random valid/ready with scoreboard
        words_in = 0;
        beats    = 0;
        cycles   = 0;
        pend     = 1'b0;
        while (words_in < 1000 && cycles < 60000) begin
            if (!pend) begin
                psum_valid = 1'($urandom_range(0, 3) != 0);
                psum       = {$urandom(), $urandom(), $urandom()};
            end
            out_ready = 1'($urandom_range(0, 3) != 0);
            #3;
            acc = psum_valid && psum_ready;
            bt  = out_valid && out_ready;
            if (bt) begin
                beats++;
                if (q.size() == 0) begin
                    check_eq("rnd_spurious_beat", 32'd1, 32'd0);
                end else begin
                    b = q.pop_front();
                    check_eq("rnd_data", 32'(out_data), 32'(b.d));
                    check_eq("rnd_idx",  32'(out_idx),  32'(b.idx));
                    check_eq("rnd_last", 32'(out_last), 32'(b.idx == NUM_COL-1));
                end
            end
            if (acc) begin
                words_in++;
                for (int c = 0; c < NUM_COL; c++) begin
                    q.push_back('{ref_col(psum, c), c});
                end
            end
            pend = psum_valid && !acc;
            next_cycle();
            cycles++;
        end
        psum_valid = 1'b0;
        out_ready  = 1'b1;
        for (int k = 0; k < 2*NUM_COL && q.size() > 0; k++) begin
            #3;
            if (out_valid) begin
                beats++;
                b = q.pop_front();
                check_eq("rnd_tail_data", 32'(out_data), 32'(b.d));
                check_eq("rnd_tail_idx",  32'(out_idx),  32'(b.idx));
                check_eq("rnd_tail_last", 32'(out_last), 32'(b.idx == NUM_COL-1));
            end
            next_cycle();
        end
        check_eq("rnd_words",    32'(words_in), 32'd1000);
        check_eq("rnd_leftover", 32'(q.size()), 32'd0);
        check_eq("rnd_beats",    32'(beats),    32'(words_in * NUM_COL));
        idle_check("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
